kevin_stream_detector: RTL and testbench

Serial front end for the Kevin-number detection path. Accepts a gated serial bit stream and assembles it into 4-bit nibbles, MSB first. Each completed nibble is presented with a one-cycle valid strobe and a registered Kevin-number flag for the downstream 4-bit detector stage. Also keeps a running hit count and the longest run of consecutive Kevin nibbles.
- Kevin set: {1, 5, 6, 7, 9, 10, 12, 14}.

---
 rtl/kevin_pkg.sv | 20 ++
 rtl/kevin_deser.sv | 66 ++++++
 rtl/kevin_stream_detector.sv | 78 +++++++
 tb/tb_kevin_stream_detector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/kevin_pkg.sv
// Shared constants and types for the Kevin-number stream detector.
// KEVIN_PARITY_EN selects 5-bit frames (4 data bits + even parity).
package kevin_pkg;

  // Bit i is set iff i is a Kevin number {1,5,6,7,9,10,12,14}.
  localparam logic [15:0] KEVIN_MASK = 16'h56E2;

`ifdef KEVIN_PARITY_EN
  localparam int FRAME_LEN = 5;
  typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_P} state_t;
`else
  localparam int FRAME_LEN = 4;
  typedef enum logic [1:0] {S_B0, S_B1, S_B2, S_B3} state_t;
`endif

  function automatic logic is_kevin(input logic [3:0] n);
    return KEVIN_MASK[n];
  endfunction

endpackage

// File: rtl/kevin_deser.sv
// Serial-to-nibble deserializer: bit-position FSM, shift register, parity check.
// With KEVIN_PARITY_EN a fifth (even-parity) bit is consumed per frame.
module kevin_deser
  import kevin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clear,
  output logic       frame_done,
  output logic [3:0] frame_data,
  output logic       parity_err
);

  // Holds every frame bit except the one arriving on the completing cycle.
  localparam int SR_W = FRAME_LEN - 1;

  state_t          state, state_nxt;
  logic [SR_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_B0;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (bit_valid && !clear) sr <= {sr[SR_W-2:0], bit_in};
  end

`ifdef KEVIN_PARITY_EN
  assign frame_data = sr;
`else
  assign frame_data = {sr, bit_in};
`endif

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    parity_err = 1'b0;
    if (clear) begin
      state_nxt = S_B0;
    end else if (bit_valid) begin
      case (state)
        S_B0: state_nxt = S_B1;
        S_B1: state_nxt = S_B2;
        S_B2: state_nxt = S_B3;
`ifdef KEVIN_PARITY_EN
        S_B3: state_nxt = S_P;
        S_P: begin
          state_nxt = S_B0;
          if (^{sr, bit_in}) parity_err = 1'b1;
          else               frame_done = 1'b1;
        end
`else
        S_B3: begin
          state_nxt  = S_B0;
          frame_done = 1'b1;
        end
`endif
        default: state_nxt = S_B0;
      endcase
    end
  end

endmodule

// File: rtl/kevin_stream_detector.sv
// Kevin-number stream detector top: hit decode, saturating counters, streak tracking.
// KEVIN_PARITY_EN (see kevin_pkg) enables per-frame even parity and parity_err.
module kevin_stream_detector
  import kevin_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic [3:0]       nibble,
  output logic             nibble_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] streak_max,
  output logic             parity_err
);

  logic             vld_p0;
  logic [3:0]       nibble_p0;
  logic             perr_p0;
  logic             hit_p0;
  logic [CNT_W-1:0] streak;
  logic [CNT_W-1:0] streak_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  kevin_deser u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .frame_done(vld_p0),
    .frame_data(nibble_p0),
    .parity_err(perr_p0)
  );

  assign hit_p0     = is_kevin(nibble_p0);
  assign streak_inc = sat_inc(streak);

  // Stage p0 -> outputs: completion strobe and assembled nibble registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibble       <= '0;
      nibble_valid <= 1'b0;
      hit          <= 1'b0;
      hit_count    <= '0;
      streak       <= '0;
      streak_max   <= '0;
      parity_err   <= 1'b0;
    end else begin
      nibble_valid <= 1'b0;
      parity_err   <= perr_p0;
      if (clear) begin
        hit_count  <= '0;
        streak     <= '0;
        streak_max <= '0;
      end else if (vld_p0) begin
        nibble       <= nibble_p0;
        hit          <= hit_p0;
        nibble_valid <= 1'b1;
        if (hit_p0) begin
          hit_count <= sat_inc(hit_count);
          streak    <= streak_inc;
          if (streak_inc > streak_max) streak_max <= streak_inc;
        end else begin
          streak <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kevin_stream_detector.sv
// Scoreboard bench for kevin_stream_detector: directed frames, CNT_W=8 and CNT_W=2 instances.
module tb_kevin_stream_detector;

`ifdef KEVIN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] nibble, nibble2;
  logic       nibble_valid, nibble_valid2;
  logic       hit, hit2;
  logic [7:0] hit_count, streak_max;
  logic [1:0] hit_count2, streak_max2;
  logic       parity_err, parity_err2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] nib;
    logic       hit;
    logic [7:0] hc;
    logic [7:0] sm;
    logic [1:0] hc2;
    logic [1:0] sm2;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  kevin_stream_detector #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .nibble(nibble), .nibble_valid(nibble_valid), .hit(hit),
    .hit_count(hit_count), .streak_max(streak_max), .parity_err(parity_err)
  );

  kevin_stream_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .nibble(nibble2), .nibble_valid(nibble_valid2), .hit(hit2),
    .hit_count(hit_count2), .streak_max(streak_max2), .parity_err(parity_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] n, input logic h, input logic [7:0] hc,
                      input logic [7:0] sm, input logic [1:0] hc2, input logic [1:0] sm2);
    exp_t e;
    e.nib = n; e.hit = h; e.hc = hc; e.sm = sm; e.hc2 = hc2; e.sm2 = sm2;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per nibble_valid pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (nibble_valid2 !== nibble_valid) chk("valid_w2", nibble_valid2, nibble_valid);
      if (nibble_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("nibble", nibble, e.nib);
          chk("hit", hit, e.hit);
          chk("hit_count", hit_count, e.hc);
          chk("streak_max", streak_max, e.sm);
          chk("hit_count_w2", hit_count2, e.hc2);
          chk("streak_max_w2", streak_max2, e.sm2);
        end
      end
    end
  end

  // Called at a negedge; presents one bit for one cycle then idles gap cycles.
  task automatic send_bit(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = ~b;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    for (int i = 3; i >= 0; i--) send_bit(n[i], (i == 0 && !PAR) ? 0 : gap);
    if (PAR) send_bit(^n, 0);
    chk("latency", nibble_valid, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_nibble"}, nibble, 0);
    chk({tag, "_valid"}, nibble_valid, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_hc"}, hit_count, 0);
    chk({tag, "_sm"}, streak_max, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_hc_w2"}, hit_count2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 0101 back-to-back
    push(4'h5, 1, 1, 1, 1, 1);
    send_nib(4'h5, 0);
    @(negedge clk);
    chk("pulse_one_cycle", nibble_valid, 0);

    // 0011 with 2-cycle gaps: miss, counts unchanged
    push(4'h3, 0, 1, 1, 1, 1);
    send_nib(4'h3, 2);

    // run 6,7,9 then miss 3 then 12
    push(4'h6, 1, 2, 1, 2, 1);
    send_nib(4'h6, 0);
    push(4'h7, 1, 3, 2, 3, 2);
    send_nib(4'h7, 0);
    push(4'h9, 1, 4, 3, 3, 3);
    send_nib(4'h9, 0);
    push(4'h3, 0, 4, 3, 3, 3);
    send_nib(4'h3, 0);
    push(4'hC, 1, 5, 3, 3, 3);
    send_nib(4'hC, 1);

    // idle: nibble/hit hold, no stray pulses
    repeat (5) @(negedge clk);
    chk("hold_nibble", nibble, 4'hC);
    chk("hold_hit", hit, 1);

    // clear, then five Kevin nibbles saturate the 2-bit instance
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_hc", hit_count, 0);
    chk("clear_sm", streak_max, 0);
    chk("clear_hold_nibble", nibble, 4'hC);
    push(4'h1, 1, 1, 1, 1, 1);
    send_nib(4'h1, 0);
    push(4'h5, 1, 2, 2, 2, 2);
    send_nib(4'h5, 0);
    push(4'h6, 1, 3, 3, 3, 3);
    send_nib(4'h6, 0);
    push(4'h7, 1, 4, 4, 3, 3);
    send_nib(4'h7, 0);
    push(4'h9, 1, 5, 5, 3, 3);
    send_nib(4'h9, 0);

    // asynchronous reset mid-frame
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    push(4'hE, 1, 1, 1, 1, 1);
    send_nib(4'hE, 0);

    // clear together with the 3rd bit drops the frame
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    bit_in = 1'b0; bit_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; clear = 1'b0;
    chk("clr3_hc", hit_count, 0);
    chk("clr3_sm", streak_max, 0);
    chk("clr3_nibble_hold", nibble, 4'hE);
    chk("clr3_hit_hold", hit, 1);
    chk("clr3_valid", nibble_valid, 0);
    push(4'hA, 1, 1, 1, 1, 1);
    send_nib(4'hA, 0);

`ifdef KEVIN_PARITY_EN
    push(4'h5, 1, 2, 2, 2, 2);
    send_nib(4'h5, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0);
    chk("perr_pulse", parity_err, 1);
    chk("perr_no_valid", nibble_valid, 0);
    @(negedge clk);
    chk("perr_one_cycle", parity_err, 0);
    chk("perr_hc", hit_count, 2);
    chk("perr_nibble_hold", nibble, 4'h5);
`else
    chk("no_parity_err", parity_err, 0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
